// File: rtl/phase_seq_pkg.sv
// Shared state encoding and default sizing for the phase sequencer.
package phase_seq_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] StIdle     = 2'd0;
  localparam logic [STATE_W-1:0] StRun      = 2'd1;
  localparam logic [STATE_W-1:0] StHaltPend = 2'd2;

  localparam int unsigned NumPhasesDef = 5;
  localparam int unsigned IdxWDef      = 3;
  localparam int unsigned CntWDef      = 16;

endpackage

// File: rtl/phase_onehot_dec.sv
// Registered binary-to-one-hot phase decode; all zeros when not enabled.
module phase_onehot_dec #(
  parameter int unsigned NUM_PHASES = 5,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [NUM_PHASES-1:0] phase_o
);

  logic [NUM_PHASES-1:0] phase_d, phase_q;

  always_comb begin
    phase_d = '0;
    for (int i = 0; i < int'(NUM_PHASES); i++) begin
      phase_d[i] = en_i && (32'(idx_i) == 32'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/phase_sequencer.sv
// One-hot CPU phase generator with run/halt, stall, single-step, phase skip
// and a completed-instruction counter. All outputs come straight from flops.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES = NumPhasesDef,
  parameter int unsigned IDX_W      = IdxWDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  halt_req,
  input  logic                  stall,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic                  skip_valid,
  input  logic [IDX_W-1:0]      skip_to,
  output logic [NUM_PHASES-1:0] phase,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  busy,
  output logic                  cycle_done,
  output logic                  skip_err,
  output logic [CNT_W-1:0]      instr_cnt
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PHASES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               adv, skip_ok, at_last;

  always_comb begin
    adv     = !stall && (!step_mode || step);
    skip_ok = 32'(skip_to) < NUM_PHASES;
    at_last = (idx_q == LastIdx);
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        idx_d = '0;
        if (run) state_d = StRun;
      end
      StRun, StHaltPend: begin
        // Halt is latched even while stalled; it only takes effect at a boundary.
        if (state_q == StRun && halt_req) state_d = StHaltPend;
        if (adv) begin
          if (skip_valid && skip_ok) begin
            idx_d = skip_to;
          end else begin
            err_d = skip_valid;
            if (at_last) begin
              done_d = 1'b1;
              cnt_d  = cnt_q + 1'b1;
              idx_d  = '0;
              if (state_q == StHaltPend || halt_req) state_d = StIdle;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  phase_onehot_dec #(
    .NUM_PHASES (NUM_PHASES),
    .IDX_W      (IDX_W)
  ) u_dec (
    .clk     (clk),
    .rst     (rst),
    .en_i    (busy_d),
    .idx_i   (idx_d),
    .phase_o (phase)
  );

  assign phase_idx  = idx_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;
  assign skip_err   = err_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench: a 5-phase instance driven from a vector table, plus a
// 3-phase/2-bit-counter instance for wrap behaviour and async reset checks.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       run, halt_req, stall, step_mode, step, skip_valid;
  logic [2:0] skip_to;
  logic [4:0] phase;
  logic [2:0] phase_idx;
  logic       busy, cycle_done, skip_err;
  logic [15:0] instr_cnt;

  logic       run2, skip_valid2;
  logic [1:0] skip_to2;
  logic [2:0] phase2;
  logic [1:0] phase_idx2;
  logic       busy2, cycle_done2, skip_err2;
  logic [1:0] instr_cnt2;

  phase_sequencer #(.NUM_PHASES(5), .IDX_W(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .stall(stall),
    .step_mode(step_mode), .step(step), .skip_valid(skip_valid), .skip_to(skip_to),
    .phase(phase), .phase_idx(phase_idx), .busy(busy), .cycle_done(cycle_done),
    .skip_err(skip_err), .instr_cnt(instr_cnt)
  );

  phase_sequencer #(.NUM_PHASES(3), .IDX_W(2), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .run(run2), .halt_req(1'b0), .stall(1'b0),
    .step_mode(1'b0), .step(1'b0), .skip_valid(skip_valid2), .skip_to(skip_to2),
    .phase(phase2), .phase_idx(phase_idx2), .busy(busy2), .cycle_done(cycle_done2),
    .skip_err(skip_err2), .instr_cnt(instr_cnt2)
  );

  typedef struct {
    logic       run, halt, stall, sm, step, sv;
    logic [2:0] st;
    logic [2:0] idx;
    logic       busy, done, err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic v(input logic r, h, s, m, p, sv, input logic [2:0] st,
                   input logic [2:0] idx, input logic b, d, e, input logic [15:0] c);
    vec_t x;
    x.run = r; x.halt = h; x.stall = s; x.sm = m; x.step = p; x.sv = sv; x.st = st;
    x.idx = idx; x.busy = b; x.done = d; x.err = e; x.cnt = c;
    vq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [2:0] idx, input logic b, d, e,
                          input logic [15:0] c);
    logic [4:0] one5;
    one5 = 5'd1;
    chk({tag, ".idx"}, 32'(phase_idx), 32'(idx));
    chk({tag, ".phase"}, 32'(phase), b ? 32'(one5 << idx) : 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(cycle_done), 32'(d));
    chk({tag, ".err"}, 32'(skip_err), 32'(e));
    chk({tag, ".cnt"}, 32'(instr_cnt), 32'(c));
  endtask

  initial begin
    //  run halt stl sm stp sv st    idx busy done err cnt
    // basic run through two cycle boundaries
    v(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 1);
    // stall three cycles at idx 2
    v(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 1);
    v(0, 0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 1);
    v(0, 0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 1);
    v(0, 0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 2);
    // legal skip 1->4, then illegal skip_to=7
    v(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2);
    v(0, 0, 0, 0, 0, 1, 4,  4, 1, 0, 0, 2);
    v(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 3);
    v(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 3);
    v(0, 0, 0, 0, 0, 1, 7,  2, 1, 0, 1, 3);
    v(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 3);
    v(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 3);
    v(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 4);
    // halt pulse mid-cycle, drain to idle, restart
    v(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 4);
    v(0, 1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 4);
    v(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 4);
    v(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 4);
    v(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 5);
    v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 5);
    v(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 5);
    // step mode: frozen 5 cycles, one step pulse advances once
    v(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 5);
    v(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 5);
    v(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 5);
    v(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 5);
    v(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 5);
    v(0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 5);
    v(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 5);
    v(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 5);
    // skip ignored while stalled (no skip_err)
    v(0, 0, 1, 0, 0, 1, 7,  2, 1, 0, 0, 5);
    v(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 5);
    v(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 5);
    // halt_req exactly at the boundary stops immediately
    v(0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 6);
    v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6);

    run = 0; halt_req = 0; stall = 0; step_mode = 0; step = 0; skip_valid = 0; skip_to = '0;
    run2 = 0; skip_valid2 = 0; skip_to2 = '0;

    tick();
    tick();
    chk_main("reset", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      run = vq[i].run; halt_req = vq[i].halt; stall = vq[i].stall;
      step_mode = vq[i].sm; step = vq[i].step; skip_valid = vq[i].sv; skip_to = vq[i].st;
      tick();
      chk_main($sformatf("vec%0d", i), vq[i].idx, vq[i].busy, vq[i].done, vq[i].err,
               vq[i].cnt);
    end
    run = 0; halt_req = 0; stall = 0; step_mode = 0; step = 0; skip_valid = 0;

    // async reset mid-operation at idx 3
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();
    chk_main("pre_rst", 3'd3, 1'b1, 1'b0, 1'b0, 16'd6);
    #2 rst = 1'b1;
    #1;
    chk_main("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    rst = 1'b0;

    // 3-phase build: one-hot wrap and 2-bit counter wrap 3->0
    run2 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int p = 0; p < 3; p++) begin
        logic [2:0] one3;
        one3 = 3'd1;
        tick();
        run2 = 1'b0;
        chk($sformatf("p3_idx_c%0d_p%0d", c, p), 32'(phase_idx2), 32'(p));
        chk($sformatf("p3_phase_c%0d_p%0d", c, p), 32'(phase2), 32'(one3 << p));
        chk($sformatf("p3_done_c%0d_p%0d", c, p), 32'(cycle_done2), 32'(c > 0 && p == 0));
        chk($sformatf("p3_cnt_c%0d_p%0d", c, p), 32'(instr_cnt2), 32'(c % 4));
      end
    end
    skip_valid2 = 1'b1;
    skip_to2 = 2'd3;
    tick();
    skip_valid2 = 1'b0;
    chk("p3_skip_err", 32'(skip_err2), 32'd1);
    chk("p3_skip_idx", 32'(phase_idx2), 32'd0);
    chk("p3_skip_cnt", 32'(instr_cnt2), 32'd1);
    chk("p3_skip_done", 32'(cycle_done2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
